// File: rtl/pwm_capture.sv
// PWM period / high-time capture with synchronized input, sticky timeout and saturating counter.
// Optional period band classifier compiled in with macro PWM_CAPTURE_BAND_EN.
module pwm_capture #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 12000000,
    parameter int unsigned TH0         = 180000,
    parameter int unsigned TH1         = 2520000,
    parameter int unsigned TH2         = 7200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             level_o,
    output logic [1:0]       band_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_HIGH = 2'b10,
        ST_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] high_lat_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             valid_q;
    logic             timeout_q;
    logic             rise_s;
    logic             fall_s;
    logic             tmo_s;
    logic             load_s;

    assign rise_s = s2_q & ~s3_q;
    assign fall_s = ~s2_q & s3_q;
    assign tmo_s  = (64'(cnt_q) >= 64'(TIMEOUT_CYC));
    assign load_s = en_i & (state_q == ST_LOW) & rise_s;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Measurement FSM with registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_lat_q  <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en_i) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                high_lat_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                        cnt_q   <= '0;
                    end
                    ST_ARM: begin
                        if (rise_s) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= CNT_ONE;
                        end else if (tmo_s) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_HIGH: begin
                        if (fall_s) begin
                            high_lat_q <= cnt_q;
                            cnt_q      <= cnt_d;
                            state_q    <= ST_LOW;
                        end else if (tmo_s) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_ARM;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_LOW: begin
                        if (rise_s) begin
                            period_q    <= cnt_q;
                            high_time_q <= high_lat_q;
                            valid_q     <= 1'b1;
                            timeout_q   <= 1'b0;
                            cnt_q       <= CNT_ONE;
                            state_q     <= ST_HIGH;
                        end else if (tmo_s) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_ARM;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PWM_CAPTURE_BAND_EN
    logic [1:0] band_q;

    function automatic logic [1:0] band_of(input logic [CNT_W-1:0] p);
        logic [1:0] b;
        if (64'(p) < 64'(TH0)) begin
            b = 2'b00;
        end else if (64'(p) < 64'(TH1)) begin
            b = 2'b01;
        end else if (64'(p) < 64'(TH2)) begin
            b = 2'b10;
        end else begin
            b = 2'b11;
        end
        return b;
    endfunction

    // Band is classified from the same count that becomes the new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_q <= 2'b00;
        end else if (load_s) begin
            band_q <= band_of(cnt_q);
        end else begin
            band_q <= band_q;
        end
    end

    assign band_o = band_q;
`else
    // Thresholds fold away at elaboration; no classifier hardware is built.
    localparam logic [1:0] BAND_OFF = ((TH0 <= TH1) && (TH1 <= TH2)) ? 2'b00 : 2'b00;
    logic unused_load_s;
    assign unused_load_s = load_s;
    assign band_o        = BAND_OFF;
`endif

    assign period_o    = period_q;
    assign high_time_o = high_time_q;
    assign valid_o     = valid_q;
    assign timeout_o   = timeout_q;
    assign level_o     = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down timing parameters (1/1200 of nominal).
module tb_pwm_capture;

`ifdef PWM_CAPTURE_BAND_EN
    localparam bit BAND_ON = 1'b1;
`else
    localparam bit BAND_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pwm;
    logic        pwm_s;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        timeout;
    logic        level;
    logic [1:0]  band;
    logic [7:0]  period_s;
    logic [7:0]  high_time_s;
    logic        valid_s;
    logic        timeout_s;
    logic        level_s;
    logic [1:0]  band_s;

    int n_checks = 0;
    int n_errors = 0;
    int vcount   = 0;
    int v0;

    pwm_capture #(.CNT_W(16), .TIMEOUT_CYC(10000), .TH0(150), .TH1(2100), .TH2(6000)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .pwm_i(pwm),
        .period_o(period), .high_time_o(high_time), .valid_o(valid),
        .timeout_o(timeout), .level_o(level), .band_o(band)
    );

    pwm_capture #(.CNT_W(8), .TIMEOUT_CYC(1000)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en_i(en), .pwm_i(pwm_s),
        .period_o(period_s), .high_time_o(high_time_s), .valid_o(valid_s),
        .timeout_o(timeout_s), .level_o(level_s), .band_o(band_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vcount++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        pwm = 1'b1;
        tick(h);
        pwm = 1'b0;
        tick(l);
    endtask

    task automatic restart();
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(2);
    endtask

    // Second rise: checks latency boundary, results, and single-cycle pulse width.
    task automatic measure(input string tag, input int p, input int h, input logic [1:0] b);
        pwm = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_early"}, valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_valid"}, valid, 1'b1);
        check_eq({tag, "_period"}, period, p);
        check_eq({tag, "_high"}, high_time, h);
        check_eq({tag, "_band"}, band, BAND_ON ? b : 2'b00);
        check_eq({tag, "_level"}, level, 1'b1);
        @(negedge clk);
        check_eq({tag, "_pulse"}, valid, 1'b0);
        @(posedge clk);
        #1;
        pwm = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_high"}, high_time, 0);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
        check_eq({tag, "_level"}, level, 0);
        check_eq({tag, "_band"}, band, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        pwm   = 1'b0;
        pwm_s = 1'b0;
        tick(3);
        check_zero("rst");

        rst_n = 1'b1;
        en    = 1'b1;
        tick(3);

        // Fast square wave.
        pulse(50, 50);
        check_eq("p100_novalid1", vcount, 0);
        measure("p100", 100, 50, 2'b00);
        check_eq("p100_count", vcount, 1);

        // Slow square wave.
        restart();
        pulse(4000, 4000);
        measure("p8000", 8000, 4000, 2'b11);

        // Timeout with input held low, then recovery.
        restart();
        v0 = vcount;
        tick(9900);
        check_eq("tmo_before", timeout, 0);
        tick(200);
        check_eq("tmo_set", timeout, 1);
        check_eq("tmo_novalid", vcount, v0);
        pulse(100, 100);
        check_eq("tmo_sticky", timeout, 1);
        measure("p200", 200, 100, 2'b01);
        check_eq("tmo_cleared", timeout, 0);

        // Enable dropped mid-HIGH: outputs hold, two fresh rises needed.
        restart();
        v0 = vcount;
        pwm = 1'b1;
        tick(30);
        en = 1'b0;
        tick(3);
        check_eq("en_hold_period", period, 200);
        en = 1'b1;
        tick(3);
        pwm = 1'b0;
        tick(70);
        pulse(30, 70);
        check_eq("en_novalid", vcount, v0);
        measure("en_p100", 100, 30, 2'b00);

        // Reset mid-LOW clears outputs immediately and restarts measurement.
        restart();
        pulse(20, 40);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        v0 = vcount;
        pulse(25, 75);
        check_eq("rst_novalid", vcount, v0);
        measure("rst_p100", 100, 25, 2'b00);

        // One-cycle glitch measured as a real pulse.
        restart();
        pulse(1, 99);
        measure("glitch", 100, 1, 2'b00);

        // Saturation on the 8-bit instance.
        restart();
        pwm_s = 1'b1;
        tick(100);
        pwm_s = 1'b0;
        tick(200);
        pwm_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sat_valid", valid_s, 1'b1);
        check_eq("sat_period", period_s, 255);
        check_eq("sat_high", high_time_s, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 32: width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT_CYC, default 12000000: cycles without an expected edge before TIMEOUT (1 s at 12 MHz).
REQ-003 Parameters TH0/TH1/TH2, defaults 180000/2520000/7200000: period thresholds for band classification.
REQ-004 CLK  input  1  system clock, 12 MHz nominal.
REQ-005 RST_N  input  1  reset; asynchronous assert, active-low, single clock domain.
REQ-006 EN  input  1  capture enable; low forces IDLE.
REQ-007 PWM_IN  input  1  asynchronous square/PWM signal under measurement.
REQ-008 PERIOD  output  CNT_W  cycles between the last two rising edges.
REQ-009 HIGH_TIME  output  CNT_W  cycles from the last rising edge to the following falling edge.
REQ-010 VALID  output  1  one-cycle pulse when PERIOD/HIGH_TIME update.
REQ-011 TIMEOUT  output  1  sticky flag: no edge seen within TIMEOUT_CYC.
REQ-012 LEVEL  output  1  synchronized PWM_IN level.
REQ-013 BAND  output  2  period class: 00 fastest .. 11 slowest, same encoding as {SW1,SW2} on the blinker.

Function
REQ-014 PWM_IN shall pass through a 2-flop synchronizer followed by a third register; rise = s2 & ~s3, fall = ~s2 & s3; LEVEL = s2.
REQ-015 States: IDLE, ARM (wait first rise), HIGH (counting to fall), LOW (counting to next rise).
REQ-016 IDLE->ARM when EN=1; any state->IDLE when EN=0, with counters cleared and outputs holding their last values.
REQ-017 ARM->HIGH on rise; counter loads 1; no VALID on this first rise.
REQ-018 HIGH: counter increments each cycle; on fall, latch the high count internally and go to LOW.
REQ-019 LOW: counter increments; on rise, PERIOD <= count, HIGH_TIME <= latched high count, VALID=1 for one cycle, counter reloads 1, go to HIGH.
REQ-020 Latency: the outputs and VALID shall update on the 3rd CLK rising edge, counting the edge that first samples PWM_IN high.
REQ-021 For clock-synchronous stimulus, PERIOD and HIGH_TIME shall equal the input period and high time exactly in CLK cycles.
REQ-022 The counter shall saturate at 2^CNT_W-1 and never wrap.
REQ-023 In ARM, HIGH or LOW, if the counter reaches TIMEOUT_CYC without the awaited edge: TIMEOUT<=1, go to ARM, no VALID.
REQ-024 TIMEOUT shall clear only on the next VALID or on reset.
REQ-025 A 1-cycle glitch pulse shall be measured as a real pulse (HIGH_TIME=1); there is no filtering.
REQ-026 BAND updates with VALID: PERIOD<TH0 ->00, <TH1 ->01, <TH2 ->10, else 11.

Reset
REQ-027 RST_N=0 shall immediately force: state IDLE, synchronizer 0, counters 0, PERIOD=0, HIGH_TIME=0, VALID=0, TIMEOUT=0, LEVEL=0, BAND=00.
REQ-028 Reset mid-measurement shall discard the partial count; the first VALID after release requires two rising edges.

Configuration
REQ-029 Macro PWM_CAPTURE_BAND_EN: when defined, the band classifier of REQ-026 is compiled in.
REQ-030 When the macro is undefined, BAND shall be a constant 00 and no comparators shall be present; all other behaviour is unchanged.

Verification
REQ-031 Synchronous square wave, period 120000, high 60000 -> after the 2nd rise VALID pulses once; PERIOD=120000, HIGH_TIME=60000, BAND=00.
REQ-032 Period 9600000, high 4800000 -> PERIOD=9600000, HIGH_TIME=4800000, BAND=11 (00 if macro undefined).
REQ-033 PWM_IN held low for 12000000 cycles after ARM -> TIMEOUT=1, no VALID; then period 240000 -> VALID, TIMEOUT=0, BAND=01.
REQ-034 EN dropped during HIGH, then restored -> no VALID until two further rises; first PERIOD is the exact next full period.
REQ-035 RST_N pulsed low mid-LOW -> all outputs 0 immediately; the measurement restarts per REQ-028.
REQ-036 Rise, 1-cycle high, low for 99 cycles, rise -> PERIOD=100, HIGH_TIME=1, VALID 3 cycles after the input rise.
